// File: rtl/pixel_scanout.sv
`default_nettype none
// ============================================================================
// Module   : pixel_scanout
// Purpose  : Display-side consumer of the image source. Pulls 24-bit RGB
//            pixels through a one-bit fetch strobe into a small FIFO and
//            scans them out with raster timing for a fixed active window.
//            Absorbs the source's one-cycle read latency and stops the
//            source from running ahead of the raster.
// Ports    : clk         - system clock, rising edge
//            rst         - synchronous active-high reset
//            enable      - run request, sampled at frame boundaries only
//            pix_in      - source pixel, valid the cycle after fetch
//            fetch       - one-pixel request to the source
//            rgb         - registered pixel {R,G,B}
//            de          - active-video qualifier
//            hsync/vsync - active-low syncs
//            frame_start - one-cycle pulse on the first active pixel
//            underflow   - sticky, FIFO empty while a pixel was due
// Options  : SCANOUT_UNDERFLOW_HOLD_EN - when defined, a starved pixel
//            repeats the last popped pixel instead of black.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_scanout #(
  parameter int H_ACTIVE   = 100,
  parameter int H_FP       = 4,
  parameter int H_SYNC     = 8,
  parameter int H_BP       = 4,
  parameter int V_ACTIVE   = 100,
  parameter int V_FP       = 2,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] pix_in,
  output logic        fetch,
  output logic [23:0] rgb,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        underflow
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare value so every boundary constant (up to the total) fits.
  localparam int HW        = $clog2(H_TOTAL + 1);
  localparam int VW        = $clog2(V_TOTAL + 1);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = AW + 1;
  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int FW        = $clog2(FRAME_PIX + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [FW-1:0] FPIX_C   = FW'(FRAME_PIX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    SCAN    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [FW-1:0] fetch_cnt_q, fetch_cnt_d;
  logic          fetch_dly_q, fetch_dly_d;
  logic [23:0]   mem_q [FIFO_DEPTH];

  logic [23:0]   rgb_q, rgb_d;
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          fs_q, fs_d;
  logic          uflow_q, uflow_d;

`ifdef SCANOUT_UNDERFLOW_HOLD_EN
  logic [23:0]   last_q, last_d;
`endif

  logic          frame_end;
  logic          flush;
  logic          active;
  logic          room;
  logic          push;
  logic          pop;
  logic          starve;

  // --------------------------------------------------------------------------
  // Raster decode, FIFO control and next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    frame_end = (state_q == SCAN) && (h_q == H_LAST) && (v_q == V_LAST);
    // Leaving SCAN for IDLE discards anything buffered or in flight.
    flush     = frame_end && !enable;
    active    = (state_q == SCAN) && (h_q < H_ACT) && (v_q < V_ACT);
    // Pending pixels count against room so the FIFO can never be overrun.
    room      = (count_q + CW'(fetch_dly_q)) < DEPTH_C;
    // No fetch on the final cycle of a stopping frame: its pixel would be
    // flushed and lost from the source's sequence.
    fetch     = (state_q != IDLE) && room && (fetch_cnt_q < FPIX_C) && !flush;
    push      = fetch_dly_q;
    pop       = active && (count_q != '0);
    starve    = active && (count_q == '0);

    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fetch_dly_d = fetch;
    fetch_cnt_d = fetch_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    // A fetch on the wrap cycle already belongs to the next frame's budget.
    if (frame_end)  fetch_cnt_d = fetch ? FW'(1) : '0;
    else if (fetch) fetch_cnt_d = fetch_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (enable) state_d = PREFILL;
      end
      PREFILL: begin
        // Switch on the edge that makes the FIFO full, so SCAN starts with
        // FIFO_DEPTH entries ready.
        if (count_d == DEPTH_C) state_d = SCAN;
      end
      SCAN: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
        if (flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      fetch_dly_d = 1'b0;
      fetch_cnt_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Registered display outputs, all decoded from the same counter state
  // --------------------------------------------------------------------------
  always_comb begin
    rgb_d   = '0;
    de_d    = active;
    hsync_d = !((state_q == SCAN) && (h_q >= HS_START) && (h_q < HS_END));
    vsync_d = !((state_q == SCAN) && (v_q >= VS_START) && (v_q < VS_END));
    fs_d    = active && (h_q == '0) && (v_q == '0);
    uflow_d = uflow_q || starve;

`ifdef SCANOUT_UNDERFLOW_HOLD_EN
    last_d = last_q;
    if (pop) begin
      rgb_d  = mem_q[rd_ptr_q];
      last_d = mem_q[rd_ptr_q];
    end else if (starve) begin
      rgb_d  = last_q;
    end
`else
    if (pop) rgb_d = mem_q[rd_ptr_q];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      h_q         <= '0;
      v_q         <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fetch_cnt_q <= '0;
      fetch_dly_q <= 1'b0;
      rgb_q       <= '0;
      de_q        <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      fs_q        <= 1'b0;
      uflow_q     <= 1'b0;
`ifdef SCANOUT_UNDERFLOW_HOLD_EN
      last_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fetch_cnt_q <= fetch_cnt_d;
      fetch_dly_q <= fetch_dly_d;
      rgb_q       <= rgb_d;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      fs_q        <= fs_d;
      uflow_q     <= uflow_d;
`ifdef SCANOUT_UNDERFLOW_HOLD_EN
      last_q      <= last_d;
`endif
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pix_in;
  end

  assign rgb         = rgb_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;
  assign underflow   = uflow_q;

endmodule
`default_nettype wire
